// File: rtl/sbp_lookup_ingress.sv
// sbp_lookup_ingress: merges lookup requests and table-update writes into the first lookup stage.
// Latency: 1 cycle from the accepting handshake to the registered pipeline outputs.
// Backpressure: lookups are held off when no credits remain. Updates are held off only while an eligible lookup has priority.
//
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   lkp_valid_i/ready_o      - lookup request handshake, lkp_ip_addr_i carries the address
//   upd_valid_i/ready_o      - update request handshake, upd_* carry the table write
//   credit_return_i          - one pulse per lookup result consumed downstream
//   update_o ... result_o    - registered command to the first lookup stage
//   credit_cnt_o             - lookups that may still be issued
//   credit_err_o             - sticky flag, set by a credit return while the count is full
// Optional feature macro: SBP_INGRESS_STATS_EN adds lkp_count_o / upd_count_o.
// These are saturating counters of granted lookups and granted updates.

module sbp_lookup_ingress #(
  parameter int STAGE_ID_BITS = 6,
  parameter int LOCATION_BITS = 11,
  parameter int RESULT_BITS   = 24,
  parameter int CREDITS       = 16,
  parameter int MAX_UPD_BURST = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     lkp_valid_i,
  output logic                     lkp_ready_o,
  input  logic [31:0]              lkp_ip_addr_i,
  input  logic                     upd_valid_i,
  output logic                     upd_ready_o,
  input  logic [31:0]              upd_prefix_i,
  input  logic [5:0]               upd_prefix_len_i,
  input  logic [STAGE_ID_BITS-1:0] upd_stage_id_i,
  input  logic [LOCATION_BITS-1:0] upd_location_i,
  input  logic [RESULT_BITS-1:0]   upd_result_i,
  input  logic                     credit_return_i,
  output logic                     update_o,
  output logic [31:0]              ip_addr_o,
  output logic [5:0]               bit_pos_o,
  output logic [STAGE_ID_BITS-1:0] stage_id_o,
  output logic [LOCATION_BITS-1:0] location_o,
  output logic [RESULT_BITS-1:0]   result_o,
  output logic [7:0]               credit_cnt_o,
`ifdef SBP_INGRESS_STATS_EN
  output logic [31:0]              lkp_count_o,
  output logic [31:0]              upd_count_o,
`endif
  output logic                     credit_err_o
);

  localparam logic [7:0] CREDIT_MAX = 8'(CREDITS);
  localparam logic [4:0] BURST_MAX  = 5'(MAX_UPD_BURST);

  typedef enum logic {UPD_PRIO = 1'b0, LKP_PRIO = 1'b1} arb_state_t;

  arb_state_t state, state_nxt;
  logic [3:0] burst_cnt;
  logic       has_credit;
  logic       lkp_elig;
  logic       lkp_gnt;
  logic       upd_gnt;
  logic [4:0] burst_inc;

  assign has_credit = (credit_cnt_o != 8'd0);
  assign lkp_elig   = lkp_valid_i && has_credit;
  assign lkp_gnt    = lkp_valid_i && lkp_ready_o;
  assign upd_gnt    = upd_valid_i && upd_ready_o;
  assign burst_inc  = {1'b0, burst_cnt} + 5'd1;

  // Arbiter: readies are derived from state so that at most one grant can occur per cycle.
  // In LKP_PRIO with zero credits the lookup is not eligible, so updates keep flowing.
  always_comb begin
    state_nxt   = state;
    lkp_ready_o = 1'b0;
    upd_ready_o = 1'b0;
    if (!rst) begin
      if (state == LKP_PRIO) begin
        lkp_ready_o = has_credit;
        upd_ready_o = !lkp_elig;
        if (lkp_gnt || !lkp_valid_i) begin
          state_nxt = UPD_PRIO;
        end
      end else begin
        upd_ready_o = 1'b1;
        lkp_ready_o = has_credit && !upd_valid_i;
        if (upd_gnt && lkp_valid_i && (burst_inc >= BURST_MAX)) begin
          state_nxt = LKP_PRIO;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= UPD_PRIO;
    end else begin
      state <= state_nxt;
    end
  end

  // The burst counter only tracks updates that were granted while a lookup was waiting.
  // It saturates, because with zero credits updates may keep winning while in LKP_PRIO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_cnt <= 4'd0;
    end else if (!lkp_valid_i || lkp_gnt) begin
      burst_cnt <= 4'd0;
    end else if (upd_gnt && (burst_cnt != 4'hF)) begin
      burst_cnt <= burst_cnt + 4'd1;
    end
  end

  // Credits: a grant and a return in the same cycle cancel out.
  // A return while the count is full is dropped and latched as an error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit_cnt_o <= CREDIT_MAX;
      credit_err_o <= 1'b0;
    end else if (lkp_gnt && !credit_return_i) begin
      credit_cnt_o <= credit_cnt_o - 8'd1;
    end else if (!lkp_gnt && credit_return_i) begin
      if (credit_cnt_o == CREDIT_MAX) begin
        credit_err_o <= 1'b1;
      end else begin
        credit_cnt_o <= credit_cnt_o + 8'd1;
      end
    end
  end

  // Stage command register. A cycle with no grant issues a bubble, and stage id 0 selects no stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      update_o   <= 1'b0;
      ip_addr_o  <= 32'd0;
      bit_pos_o  <= 6'd0;
      stage_id_o <= '0;
      location_o <= '0;
      result_o   <= '0;
    end else if (upd_gnt) begin
      update_o   <= 1'b1;
      ip_addr_o  <= upd_prefix_i;
      bit_pos_o  <= upd_prefix_len_i;
      stage_id_o <= upd_stage_id_i;
      location_o <= upd_location_i;
      result_o   <= upd_result_i;
    end else if (lkp_gnt) begin
      update_o   <= 1'b0;
      ip_addr_o  <= lkp_ip_addr_i;
      bit_pos_o  <= 6'd0;
      stage_id_o <= STAGE_ID_BITS'(1);
      location_o <= '0;
      result_o   <= '0;
    end else begin
      update_o   <= 1'b0;
      ip_addr_o  <= 32'd0;
      bit_pos_o  <= 6'd0;
      stage_id_o <= '0;
      location_o <= '0;
      result_o   <= '0;
    end
  end

`ifdef SBP_INGRESS_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lkp_count_o <= 32'd0;
      upd_count_o <= 32'd0;
    end else begin
      if (lkp_gnt && (lkp_count_o != 32'hFFFF_FFFF)) begin
        lkp_count_o <= lkp_count_o + 32'd1;
      end
      if (upd_gnt && (upd_count_o != 32'hFFFF_FFFF)) begin
        upd_count_o <= upd_count_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sbp_lookup_ingress.sv
// Testbench for sbp_lookup_ingress, built with the default parameters.
// The stimulus process queues the expected stage commands in grant order.
// A monitor pops and compares every non-bubble output.
module tb_sbp_lookup_ingress;

  typedef struct packed {
    logic        upd;
    logic [31:0] ip;
    logic [5:0]  pos;
    logic [5:0]  stage;
    logic [10:0] loc;
    logic [23:0] res;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        lkp_valid, lkp_ready;
  logic [31:0] lkp_ip_addr;
  logic        upd_valid, upd_ready;
  logic [31:0] upd_prefix;
  logic [5:0]  upd_prefix_len;
  logic [5:0]  upd_stage_id;
  logic [10:0] upd_location;
  logic [23:0] upd_result;
  logic        credit_return;
  logic        update;
  logic [31:0] ip_addr;
  logic [5:0]  bit_pos;
  logic [5:0]  stage_id;
  logic [10:0] location;
  logic [23:0] result;
  logic [7:0]  credit_cnt;
  logic        credit_err;
`ifdef SBP_INGRESS_STATS_EN
  logic [31:0] lkp_count, upd_count;
`endif

  int checks   = 0;
  int failures = 0;
  int lidx     = 0;
  int uidx     = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  sbp_lookup_ingress dut (
    .clk             (clk),
    .rst             (rst),
    .lkp_valid_i     (lkp_valid),
    .lkp_ready_o     (lkp_ready),
    .lkp_ip_addr_i   (lkp_ip_addr),
    .upd_valid_i     (upd_valid),
    .upd_ready_o     (upd_ready),
    .upd_prefix_i    (upd_prefix),
    .upd_prefix_len_i(upd_prefix_len),
    .upd_stage_id_i  (upd_stage_id),
    .upd_location_i  (upd_location),
    .upd_result_i    (upd_result),
    .credit_return_i (credit_return),
    .update_o        (update),
    .ip_addr_o       (ip_addr),
    .bit_pos_o       (bit_pos),
    .stage_id_o      (stage_id),
    .location_o      (location),
    .result_o        (result),
    .credit_cnt_o    (credit_cnt),
`ifdef SBP_INGRESS_STATS_EN
    .lkp_count_o     (lkp_count),
    .upd_count_o     (upd_count),
`endif
    .credit_err_o    (credit_err)
  );

  function automatic exp_t exp_l(input int i);
    exp_t e;
    e.upd = 1'b0; e.ip = 32'hC0A8_0101 + 32'(i); e.pos = 6'd0;
    e.stage = 6'd1; e.loc = 11'd0; e.res = 24'd0;
    return e;
  endfunction

  function automatic exp_t exp_u(input int i);
    exp_t e;
    e.upd = 1'b1; e.ip = 32'h0A00_0000 + 32'(i << 16); e.pos = 6'(8 + (i % 24));
    e.stage = 6'(3 + (i % 50)); e.loc = 11'(5 + i); e.res = 24'hABC000 + 24'(i);
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, want);
    end
  endtask

  task automatic chk_bubble(input string name);
    chk(name, 64'({update, ip_addr, bit_pos, stage_id, location, result}), 64'd0);
  endtask

  task automatic drive_data();
    exp_t u;
    u = exp_u(uidx);
    lkp_ip_addr    = exp_l(lidx).ip;
    upd_prefix     = u.ip;
    upd_prefix_len = u.pos;
    upd_stage_id   = u.stage;
    upd_location   = u.loc;
    upd_result     = u.res;
  endtask

  // One clock of stimulus, entered and left at a falling edge; indices advance on handshakes.
  task automatic cycle(input bit lv, input bit uv, input bit cr);
    bit lhs, uhs;
    lkp_valid = lv; upd_valid = uv; credit_return = cr;
    drive_data();
    #1;
    if (lv && uv) chk("ready_exclusive", 64'(lkp_ready & upd_ready), 64'd0);
    lhs = lv & lkp_ready;
    uhs = uv & upd_ready;
    @(posedge clk);
    if (lhs) lidx++;
    if (uhs) uidx++;
    @(negedge clk);
  endtask

  // Monitor: every non-bubble command must match the head of the expectation queue.
  always @(negedge clk) begin
    if (!rst && (update || stage_id != 6'd0)) begin
      exp_t got, e;
      got = {update, ip_addr, bit_pos, stage_id, location, result};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output got=%0h exp=none", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          failures++;
          $display("FAIL stage_cmd got=%0h exp=%0h", got, e);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; lkp_valid = 1'b1; upd_valid = 1'b1; credit_return = 1'b0;
    drive_data();
    repeat (2) @(negedge clk);
    chk("rst_lkp_ready", 64'(lkp_ready), 64'd0);
    chk("rst_upd_ready", 64'(upd_ready), 64'd0);
    chk_bubble("rst_bubble");
    chk("rst_credits", 64'(credit_cnt), 64'd16);
    chk("rst_err", 64'(credit_err), 64'd0);
    lkp_valid = 1'b0; upd_valid = 1'b0;
    rst = 1'b0;

    // Single lookup, then a single update
    begin
      exp_t e;
      e.upd = 1'b0; e.ip = 32'hC0A8_0101; e.pos = 6'd0; e.stage = 6'd1; e.loc = 11'd0; e.res = 24'd0;
      exp_q.push_back(e);
    end
    cycle(1, 0, 0);
    chk("lkp_credit_15", 64'(credit_cnt), 64'd15);
    cycle(0, 0, 0);
    chk_bubble("idle_bubble");
    cycle(0, 0, 1);
    chk("credit_back_16", 64'(credit_cnt), 64'd16);
    begin
      exp_t e;
      e.upd = 1'b1; e.ip = 32'h0A00_0000; e.pos = 6'd8; e.stage = 6'd3; e.loc = 11'd5; e.res = 24'hABC000;
      exp_q.push_back(e);
    end
    cycle(0, 1, 0);
    chk("upd_no_credit_use", 64'(credit_cnt), 64'd16);

    // Both requesters held high: U,U,U,U,L,U,U,U,U,L
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 4; j++) exp_q.push_back(exp_u(1 + 4 * k + j));
      exp_q.push_back(exp_l(1 + k));
    end
    repeat (10) cycle(1, 1, 0);
    chk("burst_credits_14", 64'(credit_cnt), 64'd14);
    repeat (2) cycle(0, 0, 1);

    // Exhaust credits with 16 lookups
    for (int j = 0; j < 16; j++) exp_q.push_back(exp_l(3 + j));
    repeat (16) cycle(1, 0, 0);
    chk("credits_zero", 64'(credit_cnt), 64'd0);
    lkp_valid = 1'b1; upd_valid = 1'b0;
    #1;
    chk("lkp_ready_17th", 64'(lkp_ready), 64'd0);
    // Updates continue at zero credits, including in LKP_PRIO.
    // After the credit returns, the waiting lookup wins at once.
    for (int j = 0; j < 6; j++) exp_q.push_back(exp_u(9 + j));
    exp_q.push_back(exp_l(19));
    repeat (5) cycle(1, 1, 0);
    cycle(1, 1, 1);
    chk("credit_ret_1", 64'(credit_cnt), 64'd1);
    cycle(1, 1, 0);
    chk("lkp17_taken", 64'(credit_cnt), 64'd0);
    repeat (16) cycle(0, 0, 1);
    chk("credits_refill", 64'(credit_cnt), 64'd16);

    // Overflowing credit return
    chk("err_clear", 64'(credit_err), 64'd0);
    cycle(0, 0, 1);
    chk("ovf_count", 64'(credit_cnt), 64'd16);
    chk("ovf_err", 64'(credit_err), 64'd1);
    repeat (3) cycle(0, 0, 0);
    chk("err_sticky", 64'(credit_err), 64'd1);

    // Reset mid-burst with 10 credits
    for (int j = 0; j < 6; j++) exp_q.push_back(exp_l(20 + j));
    repeat (6) cycle(1, 0, 0);
    chk("credits_10", 64'(credit_cnt), 64'd10);
    for (int j = 0; j < 3; j++) exp_q.push_back(exp_u(15 + j));
    repeat (3) cycle(1, 1, 0);
    lkp_valid = 1'b1; upd_valid = 1'b1;
    drive_data();
    @(posedge clk);
    uidx++;                   // this grant is wiped by the reset below
    #2 rst = 1'b1;
    #1;
    chk_bubble("midrst_bubble");
    chk("midrst_credits", 64'(credit_cnt), 64'd16);
    chk("midrst_lkp_ready", 64'(lkp_ready), 64'd0);
    chk("midrst_upd_ready", 64'(upd_ready), 64'd0);
    chk("midrst_err", 64'(credit_err), 64'd0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    // The arbiter history is gone, so the order starts again with four updates.
    for (int j = 0; j < 4; j++) exp_q.push_back(exp_u(19 + j));
    exp_q.push_back(exp_l(26));
    repeat (5) cycle(1, 1, 0);
    chk("post_rst_credits", 64'(credit_cnt), 64'd15);
    repeat (2) cycle(0, 0, 0);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
